// File: rtl/avalon_led_pio.sv
// Avalon-MM output PIO for board LEDs: DATA with atomic set/clear/toggle, per-bit blink, prescaler.
// Latency: writes take effect at the strobe edge; avs_readdata is registered, valid one cycle after avs_read.
// Backpressure: none; every access completes in its strobe cycle (no wait states).
//
// Ports:
//   clk_clk        in   system clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   avs_address    in   register word address (0..7)
//   avs_read       in   read strobe
//   avs_write      in   write strobe
//   avs_writedata  in   32-bit write data
//   avs_readdata   out  32-bit registered read data
//   led_export     out  WIDTH-bit LED drive, active-high
module avalon_led_pio #(
   parameter int                 WIDTH     = 8,
   parameter int                 DIV_W     = 24,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   parameter logic [DIV_W-1:0]   DIV_RESET = '0
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [2:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [WIDTH-1:0]  led_export
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_SET    = 3'd1;
   localparam logic [2:0] A_CLR    = 3'd2;
   localparam logic [2:0] A_TGL    = 3'd3;
   localparam logic [2:0] A_BLINK  = 3'd4;
   localparam logic [2:0] A_DIV    = 3'd5;
   localparam logic [2:0] A_STATUS = 3'd6;

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] blink_en_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt_q;
   logic             phase_q;
   logic [31:0]      readdata_q;
   logic [31:0]      rd_mux;

   logic [WIDTH-1:0] wr_led;
   logic [DIV_W-1:0] wr_div;
   logic             div_wr;

   // Upper write-data bits beyond WIDTH/DIV_W are deliberately ignored.
   logic             unused_wdata;
   assign unused_wdata = ^avs_writedata;

   assign wr_led = avs_writedata[WIDTH-1:0];
   assign wr_div = avs_writedata[DIV_W-1:0];
   assign div_wr = avs_write && (avs_address == A_DIV);

   // LED pattern and blink-enable registers.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         data_q     <= RESET_VAL;
         blink_en_q <= '0;
      end else if (avs_write) begin
         case (avs_address)
            A_DATA:  data_q     <= wr_led;
            A_SET:   data_q     <= data_q | wr_led;
            A_CLR:   data_q     <= data_q & ~wr_led;
            A_TGL:   data_q     <= data_q ^ wr_led;
            A_BLINK: blink_en_q <= wr_led;
            default: ;
         endcase
      end
   end

   // Prescaler: reload-and-toggle when cnt hits zero, giving a phase period of
   // 2*(DIV+1) cycles. A DIV write restarts the count from the new value but
   // keeps the current phase, except that DIV=0 parks phase at 0.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         div_q   <= DIV_RESET;
         cnt_q   <= DIV_RESET;
         phase_q <= 1'b0;
      end else if (div_wr) begin
         div_q <= wr_div;
         cnt_q <= wr_div;
         if (wr_div == '0) begin
            phase_q <= 1'b0;
         end
      end else if (div_q == '0) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q   <= div_q;
         phase_q <= ~phase_q;
      end else begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

   // Read mux samples pre-write state, so a same-cycle read+write returns the old value.
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         A_DATA, A_SET, A_CLR, A_TGL: rd_mux[WIDTH-1:0] = data_q;
         A_BLINK:                     rd_mux[WIDTH-1:0] = blink_en_q;
         A_DIV:                       rd_mux[DIV_W-1:0] = div_q;
         A_STATUS:                    rd_mux[1:0]       = {(div_q != '0), phase_q};
         default:                     rd_mux            = '0;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         readdata_q <= '0;
      end else if (avs_read) begin
         readdata_q <= rd_mux;
      end
   end

   assign avs_readdata = readdata_q;

   // Blinking bits go dark during phase 1.
   assign led_export = data_q & ~(blink_en_q & {WIDTH{phase_q}});

endmodule

// File: tb/tb_avalon_led_pio.sv
module tb_avalon_led_pio;

   localparam int WIDTH = 8;
   localparam int DIV_W = 24;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b0;
   logic [2:0]        avs_address = '0;
   logic              avs_read = 1'b0;
   logic              avs_write = 1'b0;
   logic [31:0]       avs_writedata = '0;
   logic [31:0]       avs_readdata;
   logic [WIDTH-1:0]  led_export;

   avalon_led_pio #(
      .WIDTH(WIDTH), .DIV_W(DIV_W), .RESET_VAL(8'hA5), .DIV_RESET(24'd0)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .led_export(led_export)
   );

   always #5 clk_clk = ~clk_clk;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   // ---------------- behavioural model ----------------
   // Phase is derived arithmetically: after a nonzero DIV is written at edge e0
   // with phase p0, the phase flips every DIV+1 edges.
   logic [WIDTH-1:0] m_data, m_blink;
   logic [DIV_W-1:0] m_div;
   logic [31:0]      m_rd;
   longint           ec;
   longint           m_e0;
   bit               m_p0;

   function automatic bit phase_at(longint t);
      if (m_div == 0) return 1'b0;
      return m_p0 ^ bit'(((t - m_e0) / (longint'(m_div) + 1)) % 2);
   endfunction

   function automatic logic [31:0] read_val(logic [2:0] a, bit ph);
      case (a)
         3'd0, 3'd1, 3'd2, 3'd3: return {24'd0, m_data};
         3'd4:                   return {24'd0, m_blink};
         3'd5:                   return {8'd0, m_div};
         3'd6:                   return {30'd0, (m_div != 0), ph};
         default:                return 32'd0;
      endcase
   endfunction

   function automatic void model_reset();
      m_data  = 8'hA5;
      m_blink = '0;
      m_div   = '0;
      m_rd    = '0;
      m_e0    = ec;
      m_p0    = 1'b0;
   endfunction

   function automatic void model_step(logic [2:0] a, logic rd, logic wr, logic [31:0] wd);
      bit ph;
      ph = phase_at(ec);
      if (rd) m_rd = read_val(a, ph);
      ec++;
      if (wr) begin
         case (a)
            3'd0: m_data  = wd[7:0];
            3'd1: m_data  = m_data | wd[7:0];
            3'd2: m_data  = m_data & ~wd[7:0];
            3'd3: m_data  = m_data ^ wd[7:0];
            3'd4: m_blink = wd[7:0];
            3'd5: begin
               m_div = wd[23:0];
               m_e0  = ec;
               m_p0  = (wd[23:0] == 0) ? 1'b0 : ph;
            end
            default: ;
         endcase
      end
   endfunction

   always @(posedge clk_clk) begin
      if (!reset_reset_n) model_reset();
      else model_step(avs_address, avs_read, avs_write, avs_writedata);
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous compare against the model, away from the active edge.
   always @(negedge clk_clk) begin
      if (run) begin
         chk("led_model", {24'd0, led_export},
             {24'd0, m_data & ~(m_blink & {WIDTH{phase_at(ec)}})});
         chk("rdata_model", avs_readdata, m_rd);
      end
   end

   // One bus cycle, driven from a negedge; returns at the following negedge.
   task automatic cyc(logic [2:0] a, logic rd, logic wr, logic [31:0] wd);
      avs_address   = a;
      avs_read      = rd;
      avs_write     = wr;
      avs_writedata = wd;
      @(negedge clk_clk);
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) @(negedge clk_clk);
   endtask

   initial begin
      ec = 0;
      model_reset();
      run = 1'b1;

      // 1: reset values
      idle(2);
      chk("reset_led", {24'd0, led_export}, 32'h0000_00A5);
      chk("reset_rdata", avs_readdata, 32'h0);
      reset_reset_n = 1'b1;
      idle(1);
      chk("post_reset_led", {24'd0, led_export}, 32'h0000_00A5);
      cyc(3'd0, 1'b1, 1'b0, 32'h0);
      chk("read_reset_data", avs_readdata, 32'h0000_00A5);

      // 2: atomic set/clear/toggle
      cyc(3'd0, 1'b0, 1'b1, 32'h0F);
      chk("data_wr", {24'd0, led_export}, 32'h0F);
      cyc(3'd1, 1'b0, 1'b1, 32'hFFFF_FF30);
      chk("set", {24'd0, led_export}, 32'h3F);
      cyc(3'd2, 1'b0, 1'b1, 32'h03);
      chk("clr", {24'd0, led_export}, 32'h3C);
      cyc(3'd3, 1'b0, 1'b1, 32'hFF);
      chk("tgl", {24'd0, led_export}, 32'hC3);
      cyc(3'd3, 1'b1, 1'b0, 32'h0);
      chk("read_tgl_addr", avs_readdata, 32'hC3);

      // 3: blink bit0 with DIV=3, period 8
      cyc(3'd0, 1'b0, 1'b1, 32'hFF);
      cyc(3'd4, 1'b0, 1'b1, 32'h01);
      cyc(3'd5, 1'b0, 1'b1, 32'h3);
      for (int i = 0; i < 8; i++) begin
         chk("blink_seq", {24'd0, led_export}, (i < 4) ? 32'hFF : 32'hFE);
         @(negedge clk_clk);
      end
      idle(4);
      chk("blink_phase1", {24'd0, led_export}, 32'hFE);

      // 4: DIV=0 mid-blink forces phase 0
      cyc(3'd5, 1'b0, 1'b1, 32'h0);
      chk("div0_led", {24'd0, led_export}, 32'hFF);
      cyc(3'd6, 1'b1, 1'b0, 32'h0);
      chk("status0", avs_readdata, 32'h0);
      cyc(3'd5, 1'b0, 1'b1, 32'h2);
      cyc(3'd6, 1'b1, 1'b1, 32'hFFFF_FFFF);
      chk("status_div", avs_readdata, 32'h2);

      // 5: same-cycle read+write returns old value
      cyc(3'd0, 1'b0, 1'b1, 32'h12);
      cyc(3'd0, 1'b1, 1'b1, 32'h34);
      chk("rw_old", avs_readdata, 32'h12);
      cyc(3'd0, 1'b1, 1'b0, 32'h0);
      chk("rw_new", avs_readdata, 32'h34);
      cyc(3'd7, 1'b1, 1'b1, 32'hDEAD_BEEF);
      chk("reserved", avs_readdata, 32'h0);

      // 6: asynchronous reset mid-blink
      cyc(3'd0, 1'b0, 1'b1, 32'hFF);
      cyc(3'd4, 1'b0, 1'b1, 32'hFF);
      cyc(3'd5, 1'b0, 1'b1, 32'h1);
      cyc(3'd0, 1'b1, 1'b0, 32'h0);
      idle(3);
      #2;
      reset_reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_led", {24'd0, led_export}, 32'hA5);
      chk("async_rdata", avs_readdata, 32'h0);
      idle(3);
      reset_reset_n = 1'b1;
      cyc(3'd5, 1'b1, 1'b0, 32'h0);
      chk("div_after_reset", avs_readdata, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [2:0]  a;
         logic [31:0] wd;
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (a == 3'd5) wd = ($urandom_range(0, 9) == 0) ? 32'h0 : 32'($urandom_range(1, 6)) | (wd & 32'hFF00_0000);
         if ($urandom_range(0, 3) == 0)
            cyc(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd);
         else
            cyc(a, 1'($urandom_range(0, 1)), 1'b0, wd);
         if (i == 1500) begin
            #3;
            reset_reset_n = 1'b0;
            model_reset();
            #1;
            chk("rand_async_led", {24'd0, led_export}, 32'hA5);
            @(negedge clk_clk);
            reset_reset_n = 1'b1;
         end
      end

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
